// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone types and arbiter state encoding shared by wb_arbiter, cpu_wb and mem.
//   wb_adr_t    - 30-bit word address
//   wb_dat_t    - 32-bit data word
//   wb_sel_t    - 4-bit byte selects
//   arb_state_e - arbiter FSM state (IDLE, BUSY, ERR)
package wb_pkg;

    typedef logic [29:0] wb_adr_t;
    typedef logic [31:0] wb_dat_t;
    typedef logic [3:0]  wb_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   i_req   - request vector, one bit per master
//   i_last  - index of the most recently served master
//   o_idx   - first requester found starting at i_last+1 and wrapping
//   o_valid - at least one request is present
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_last,
    output logic [2:0]   o_idx,
    output logic         o_valid
);

    logic [3:0] w_dist;
    logic [3:0] w_best;

    // Each requester's distance from last+1 in wrap order; the smallest distance wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_best  = 4'hF;
        w_dist  = '0;
        for (int j = 0; j < N; j++) begin
            w_dist = (3'(j) > i_last) ? 4'(j) - {1'b0, i_last} - 4'd1
                                      : 4'(j) + 4'(N) - {1'b0, i_last} - 4'd1;
            if (i_req[j] && w_dist < w_best) begin
                w_best  = w_dist;
                o_idx   = 3'(j);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone B4 classic arbiter sharing one slave among NUM_MASTERS masters.
//   clk_i, rst_i          - Wishbone clock, asynchronous active-low reset
//   m_cyc/stb/we/adr/sel/dat_i - packed per-master request bus (master k at slice k)
//   m_ack_o, m_err_o      - per-master acknowledge / watchdog error
//   m_dat_o               - slave read data broadcast to all masters
//   s_cyc/stb/we/adr/sel/dat_o - slave-side bus driven from the granted master
//   s_ack_i, s_dat_i      - slave acknowledge and read data
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*30-1:0] m_adr_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*32-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [31:0]               m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [29:0]               s_adr_o,
    output logic [3:0]                s_sel_o,
    output logic [31:0]               s_dat_o,
    input  logic                      s_ack_i,
    input  logic [31:0]               s_dat_i
);

    arb_state_e r_state;
    logic [2:0] r_gnt;
    logic [2:0] r_last;
    logic [7:0] r_wd;
    logic [2:0] w_pick;
    logic       w_valid;
    logic       w_busy;
    logic       w_cyc;
    logic       w_stb;
    logic       w_we;
    logic       w_wd_hit;
    wb_adr_t    w_adr;
    wb_sel_t    w_sel;
    wb_dat_t    w_dat;

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .i_req   (m_cyc_i),
        .i_last  (r_last),
        .o_idx   (w_pick),
        .o_valid (w_valid)
    );

    always_comb begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
        w_we  = 1'b0;
        w_adr = '0;
        w_sel = '0;
        w_dat = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (r_gnt == 3'(j)) begin
                w_cyc = m_cyc_i[j];
                w_stb = m_stb_i[j];
                w_we  = m_we_i[j];
                w_adr = m_adr_i[30*j +: 30];
                w_sel = m_sel_i[4*j +: 4];
                w_dat = m_dat_i[32*j +: 32];
            end
        end
    end

    // Strobes follow the owner's cyc so they drop in the same cycle the owner releases the bus.
    assign w_busy  = r_state == BUSY;
    assign s_cyc_o = w_busy & w_cyc;
    assign s_stb_o = s_cyc_o & w_stb;
    assign s_we_o  = s_cyc_o & w_we;
    assign s_adr_o = w_busy ? w_adr : '0;
    assign s_sel_o = w_busy ? w_sel : '0;
    assign s_dat_o = w_busy ? w_dat : '0;
    assign m_dat_o = w_busy ? s_dat_i : '0;

    assign w_wd_hit = (TIMEOUT != 0) && s_stb_o && !s_ack_i && (r_wd == 8'(TIMEOUT - 1));

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            m_ack_o[j] = w_busy && (r_gnt == 3'(j)) && s_ack_i;
            m_err_o[j] = (r_state == ERR) && (r_gnt == 3'(j));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= 3'(NUM_MASTERS - 1);
            r_wd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wd <= '0;
                    if (w_valid) begin
                        r_gnt   <= w_pick;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_cyc) begin
                        r_last  <= r_gnt;
                        r_wd    <= '0;
                        r_state <= IDLE;
                    end else if (w_wd_hit) begin
                        r_wd    <= '0;
                        r_state <= ERR;
                    end else begin
                        r_wd <= (TIMEOUT != 0 && s_stb_o && !s_ack_i) ? r_wd + 8'd1 : '0;
                    end
                end
                ERR: begin
                    // The faulting master becomes lowest priority for the next grant.
                    r_last  <= r_gnt;
                    r_wd    <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a round-robin reference model.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cyc, stb, we;
    logic [29:0] adr  [2];
    logic [3:0]  sel  [2];
    logic [31:0] wdat [2];
    logic        ack_en;
    int          checks, failures;

    logic [59:0] m_adr;
    logic [7:0]  m_sel;
    logic [63:0] m_wdat;
    logic [1:0]  m_ack, m_err;
    logic [31:0] m_dat;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [29:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat, s_rdat;

    logic [1:0]  d1_ack, d1_err;
    logic [31:0] d1_dat, d1_sdat;
    logic        d1_scyc, d1_sstb, d1_swe;
    logic [29:0] d1_sadr;
    logic [3:0]  d1_ssel;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    assign m_adr  = {adr[1], adr[0]};
    assign m_sel  = {sel[1], sel[0]};
    assign m_wdat = {wdat[1], wdat[0]};
    assign s_rdat = mem_word(s_adr);
    assign s_ack  = s_stb & ack_en;

    wb_arbiter #(.NUM_MASTERS(2), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(m_adr), .m_sel_i(m_sel), .m_dat_i(m_wdat),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel), .s_dat_o(s_dat),
        .s_ack_i(s_ack), .s_dat_i(s_rdat)
    );

    wb_arbiter #(.NUM_MASTERS(2), .TIMEOUT(0)) dut_nowd (
        .clk_i(clk), .rst_i(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(m_adr), .m_sel_i(m_sel), .m_dat_i(m_wdat),
        .m_ack_o(d1_ack), .m_err_o(d1_err), .m_dat_o(d1_dat),
        .s_cyc_o(d1_scyc), .s_stb_o(d1_sstb), .s_we_o(d1_swe), .s_adr_o(d1_sadr), .s_sel_o(d1_ssel), .s_dat_o(d1_sdat),
        .s_ack_i(1'b0), .s_dat_i(32'h0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cyc = '0;
        stb = '0;
        we  = '0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ack_en = 1'b1;
        idle_all();
        step();
        step();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc = 2'b11;
        stb = 2'b11;
        adr[0] = 30'h1;
        #12;
        checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {s_cyc, s_stb, s_we}); end
        checks++; if ({m_ack, m_err} !== 4'b0) begin failures++; $display("FAIL reset_ack_err got=%b exp=0000", {m_ack, m_err}); end
        checks++; if (s_adr !== 30'h0 || m_dat !== 32'h0) begin failures++; $display("FAIL reset_data adr=%h dat=%h exp=0", s_adr, m_dat); end
        idle_all();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        step();
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 30'h10; sel[0] = 4'hF;
        #1;
        checks++; if (s_stb !== 1'b0) begin failures++; $display("FAIL single_req_cycle_stb got=%b exp=0", s_stb); end
        step();
        checks++; if (s_stb !== 1'b1 || s_adr !== 30'h10 || s_sel !== 4'hF) begin failures++; $display("FAIL single_slave stb=%b adr=%h sel=%h exp=1/10/f", s_stb, s_adr, s_sel); end
        checks++; if (m_ack !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", m_ack); end
        checks++; if (m_dat !== mem_word(30'h10)) begin failures++; $display("FAIL single_rdata got=%h exp=%h", m_dat, mem_word(30'h10)); end
        step();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        checks++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin failures++; $display("FAIL single_drop got=%b%b exp=00", s_cyc, s_stb); end
        step();
    endtask

    task automatic test_contention();
        do_reset();
        step();
        cyc = 2'b11; stb = 2'b11; we = 2'b00; adr[0] = 30'h20; adr[1] = 30'h30;
        step();
        checks++; if (m_ack !== 2'b01 || s_adr !== 30'h20) begin failures++; $display("FAIL cont_first ack=%b adr=%h exp=01/20", m_ack, s_adr); end
        step();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        checks++; if (s_cyc !== 1'b0 || m_ack !== 2'b00) begin failures++; $display("FAIL cont_release cyc=%b ack=%b exp=0/00", s_cyc, m_ack); end
        step();
        cyc[0] = 1'b1; stb[0] = 1'b1;
        #1;
        checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL cont_turnaround got=%b exp=0", s_cyc); end
        step();
        checks++; if (m_ack !== 2'b10 || s_adr !== 30'h30) begin failures++; $display("FAIL cont_second ack=%b adr=%h exp=10/30", m_ack, s_adr); end
        step();
        cyc[1] = 1'b0; stb[1] = 1'b0;
        step();
        checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL cont_turnaround2 got=%b exp=0", s_cyc); end
        step();
        checks++; if (m_ack !== 2'b01 || s_adr !== 30'h20) begin failures++; $display("FAIL cont_third ack=%b adr=%h exp=01/20", m_ack, s_adr); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_burst();
        logic [29:0] exp_adr;
        step();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 30'h100; sel[1] = 4'h3;
        for (int b = 0; b < 4; b++) begin
            step();
            exp_adr = 30'h100 + 30'(b);
            adr[1]  = exp_adr;
            wdat[1] = $urandom;
            if (b == 0) begin cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 30'h44; end
            #1;
            checks++; if (m_ack !== 2'b10) begin failures++; $display("FAIL burst_ack beat=%0d got=%b exp=10", b, m_ack); end
            checks++; if (s_adr !== exp_adr || s_dat !== wdat[1] || s_we !== 1'b1) begin failures++; $display("FAIL burst_slave beat=%0d adr=%h dat=%h we=%b exp=%h/%h/1", b, s_adr, s_dat, s_we, exp_adr, wdat[1]); end
        end
        step();
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        #1;
        checks++; if (m_ack !== 2'b00) begin failures++; $display("FAIL burst_release_ack got=%b exp=00", m_ack); end
        step();
        checks++; if (m_ack !== 2'b00 || s_cyc !== 1'b0) begin failures++; $display("FAIL burst_idle ack=%b cyc=%b exp=00/0", m_ack, s_cyc); end
        step();
        checks++; if (m_ack !== 2'b01 || s_adr !== 30'h44 || s_we !== 1'b0) begin failures++; $display("FAIL burst_next ack=%b adr=%h we=%b exp=01/44/0", m_ack, s_adr, s_we); end
        step();
        idle_all();
        step();
    endtask

    task automatic test_watchdog();
        ack_en = 1'b0;
        step();
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 30'h77;
        step();
        checks++; if (s_stb !== 1'b1 || m_err !== 2'b00) begin failures++; $display("FAIL wd_start stb=%b err=%b exp=1/00", s_stb, m_err); end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++; if (m_err !== 2'b00 || s_stb !== 1'b1) begin failures++; $display("FAIL wd_wait cycle=%0d err=%b stb=%b exp=00/1", i, m_err, s_stb); end
        end
        step();
        checks++; if (m_err !== 2'b01) begin failures++; $display("FAIL wd_err got=%b exp=01", m_err); end
        checks++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin failures++; $display("FAIL wd_err_strobes got=%b%b exp=00", s_cyc, s_stb); end
        step();
        checks++; if (m_err !== 2'b00 || s_stb !== 1'b0) begin failures++; $display("FAIL wd_after err=%b stb=%b exp=00/0", m_err, s_stb); end
        step();
        checks++; if (s_stb !== 1'b1) begin failures++; $display("FAIL wd_regrant got=%b exp=1", s_stb); end
        ack_en = 1'b1;
        step();
        idle_all();
        step();
    endtask

    task automatic test_reset_mid();
        step();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 30'h99; wdat[1] = 32'hDEADBEEF;
        step();
        checks++; if (s_stb !== 1'b1 || s_we !== 1'b1 || m_ack !== 2'b10) begin failures++; $display("FAIL rstmid_pre stb=%b we=%b ack=%b exp=1/1/10", s_stb, s_we, m_ack); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin failures++; $display("FAIL rstmid_strobes got=%b exp=000", {s_cyc, s_stb, s_we}); end
        checks++; if ({m_ack, m_err} !== 4'b0 || s_adr !== 30'h0 || s_dat !== 32'h0) begin failures++; $display("FAIL rstmid_outputs ackerr=%b adr=%h dat=%h exp=0", {m_ack, m_err}, s_adr, s_dat); end
        idle_all();
        step();
        step();
        #2;
        rst_n = 1'b1;
        step();
        cyc = 2'b11; stb = 2'b11; we = 2'b00; adr[0] = 30'h5; adr[1] = 30'h6;
        step();
        checks++; if (m_ack !== 2'b01 || s_adr !== 30'h5) begin failures++; $display("FAIL rstmid_priority ack=%b adr=%h exp=01/5", m_ack, s_adr); end
        step();
        idle_all();
        step();
    endtask

    function automatic int rr_next(input int lst, input logic [1:0] req);
        int k;
        for (int i = 1; i <= 2; i++) begin
            k = (lst + i) % 2;
            if (req[k[0]]) return k;
        end
        return -1;
    endfunction

    task automatic test_random();
        int owner, owner_next, last;
        logic [1:0] acked, exp_ack;
        logic o;
        do_reset();
        owner = -1;
        last  = 1;
        acked = 2'b00;
        for (int n = 0; n < 400; n++) begin
            owner_next = owner;
            if (owner < 0) owner_next = rr_next(last, cyc);
            else if (!cyc[owner[0]]) begin last = owner; owner_next = -1; end
            step();
            owner = owner_next;
            for (int k = 0; k < 2; k++) begin
                if (cyc[k[0]] && acked[k[0]]) begin
                    cyc[k[0]] = 1'b0; stb[k[0]] = 1'b0; we[k[0]] = 1'b0;
                end else if (!cyc[k[0]] && $urandom_range(0, 2) == 0) begin
                    cyc[k[0]] = 1'b1; stb[k[0]] = 1'b1; we[k[0]] = 1'($urandom);
                    adr[k[0]] = 30'($urandom); wdat[k[0]] = $urandom; sel[k[0]] = 4'($urandom);
                end
            end
            #1;
            o = owner[0];
            exp_ack = (owner >= 0 && cyc[o]) ? (2'b01 << owner) : 2'b00;
            checks++; if (m_ack !== exp_ack || s_cyc !== (exp_ack != 2'b00)) begin failures++; $display("FAIL rand_grant n=%0d ack=%b cyc=%b exp_ack=%b", n, m_ack, s_cyc, exp_ack); end
            if (exp_ack != 2'b00) begin
                checks++; if (s_adr !== adr[o] || s_sel !== sel[o] || s_we !== we[o]) begin failures++; $display("FAIL rand_route n=%0d adr=%h sel=%h we=%b exp=%h/%h/%b", n, s_adr, s_sel, s_we, adr[o], sel[o], we[o]); end
                if (we[o]) begin
                    checks++; if (s_dat !== wdat[o]) begin failures++; $display("FAIL rand_wdata n=%0d got=%h exp=%h", n, s_dat, wdat[o]); end
                end else begin
                    checks++; if (m_dat !== mem_word(adr[o])) begin failures++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, m_dat, mem_word(adr[o])); end
                end
            end
            acked = exp_ack;
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_disabled();
        do_reset();
        step();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 30'h55;
        for (int i = 0; i < 1000; i++) begin
            step();
            checks++; if (d1_err !== 2'b00 || d1_ack !== 2'b00 || d1_sstb !== 1'b1 || d1_sadr !== 30'h55) begin failures++; $display("FAIL nowd_hold cycle=%0d err=%b ack=%b stb=%b adr=%h exp=00/00/1/55", i, d1_err, d1_ack, d1_sstb, d1_sadr); end
        end
        idle_all();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ack_en   = 1'b1;
        cyc = '0; stb = '0; we = '0;
        adr  = '{default: '0};
        sel  = '{default: 4'hF};
        wdat = '{default: '0};
        test_reset();
        test_single();
        test_contention();
        test_burst();
        test_watchdog();
        test_reset_mid();
        test_random();
        test_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
